// File: rtl/hdmi_axi_addr_mb.sv
// hdmi_axi_addr_mb: turns each prefetch_line pulse into a run of DRAM read requests
// (kick/busy handshake) that cover one display line in bursts of at most BURST_BYTES.
// The frame buffer is chosen at frame start; a prefetch that arrives while a line is
// still in flight is dropped but still counted, and the drop raises a sticky overrun.
//
// Ports:
//   clk_vga        video clock, all logic in this domain
//   rst_n          asynchronous active-low reset
//   framestart     one-cycle frame start pulse (resets line count, selects buffer)
//   prefetch_line  one-cycle request to fetch the next line
//   buf_sel_in     requested buffer index, sampled on framestart
//   busy           read master busy (rises after kick, falls on completion)
//   kick           one-cycle request strobe
//   read_addr      request byte address, held until the next kick
//   read_num       request byte count, held until the next kick
//   active_buf     buffer currently being read
//   line_cnt       next line index to be fetched (0..Y_SIZE)
//   line_done      one-cycle pulse after the last burst of a line completes
//   overrun        sticky dropped-prefetch flag, cleared on framestart
module hdmi_axi_addr_mb #(
    parameter int unsigned X_SIZE          = 1280,
    parameter int unsigned Y_SIZE          = 720,
    parameter int unsigned BYTES_PER_PIXEL = 4,
    parameter int unsigned BURST_BYTES     = 256,
    parameter int unsigned NUM_BUF         = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned NUM_W           = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000,
    parameter int unsigned LINE_STRIDE     = X_SIZE * BYTES_PER_PIXEL,
    parameter int unsigned FRAME_STRIDE    = LINE_STRIDE * Y_SIZE
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic              framestart,
    input  logic              prefetch_line,
    input  logic [3:0]        buf_sel_in,
    input  logic              busy,
    output logic              kick,
    output logic [ADDR_W-1:0] read_addr,
    output logic [NUM_W-1:0]  read_num,
    output logic [3:0]        active_buf,
    output logic [11:0]       line_cnt,
    output logic              line_done,
    output logic              overrun
);

    localparam int unsigned LINE_BYTES = X_SIZE * BYTES_PER_PIXEL;
    localparam int unsigned FIRST_NUM  = (LINE_BYTES < BURST_BYTES) ? LINE_BYTES : BURST_BYTES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] burst_addr;  // address of the next burst within the line
    logic [31:0]       remaining;   // bytes of the line not yet requested

    logic              buf_ok;
    logic [3:0]        eff_buf;
    logic [11:0]       eff_cnt;
    logic              pf_valid;
    logic [ADDR_W-1:0] line_addr;
    logic [NUM_W-1:0]  next_num;

    // framestart takes effect before a same-cycle prefetch_line, so the pulse
    // sees the freshly selected buffer and line 0.
    always_comb begin
        buf_ok    = ({1'b0, buf_sel_in} < 5'(NUM_BUF));
        eff_buf   = (framestart && buf_ok) ? buf_sel_in : active_buf;
        eff_cnt   = framestart ? 12'd0 : line_cnt;
        pf_valid  = prefetch_line && (eff_cnt < 12'(Y_SIZE));
        line_addr = BASE_ADDR
                  + ADDR_W'(eff_buf) * ADDR_W'(FRAME_STRIDE)
                  + ADDR_W'(eff_cnt) * ADDR_W'(LINE_STRIDE);
        next_num  = (remaining >= 32'(BURST_BYTES)) ? NUM_W'(BURST_BYTES) : NUM_W'(remaining);
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_addr <= '0;
            remaining  <= '0;
            kick       <= 1'b0;
            read_addr  <= '0;
            read_num   <= '0;
            active_buf <= 4'd0;
            line_cnt   <= 12'd0;
            line_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            kick      <= 1'b0;
            line_done <= 1'b0;

            if (framestart) begin
                overrun  <= 1'b0;
                line_cnt <= 12'd0;
                if (buf_ok) begin
                    active_buf <= buf_sel_in;
                end
            end

            // Every valid pulse advances the line count, fetched or dropped, so the
            // fetch stays aligned with the display line.
            if (pf_valid) begin
                line_cnt <= eff_cnt + 12'd1;
                if (state != IDLE) begin
                    overrun <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (pf_valid) begin
                        kick       <= 1'b1;
                        read_addr  <= line_addr;
                        read_num   <= NUM_W'(FIRST_NUM);
                        burst_addr <= line_addr + ADDR_W'(BURST_BYTES);
                        remaining  <= 32'(LINE_BYTES - FIRST_NUM);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!busy) begin
                        if (remaining != 32'd0) begin
                            kick       <= 1'b1;
                            read_addr  <= burst_addr;
                            read_num   <= next_num;
                            burst_addr <= burst_addr + ADDR_W'(BURST_BYTES);
                            remaining  <= remaining - 32'(next_num);
                            state      <= ISSUE;
                        end else begin
                            line_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_axi_addr_mb.sv
// Bench for hdmi_axi_addr_mb: two instances (256 and 200 pixel lines) share the control
// inputs; each has its own busy responder and its own transaction-level reference model.
module tb_hdmi_axi_addr_mb;

    localparam int unsigned Y     = 256;
    localparam int unsigned NBUF  = 2;
    localparam int unsigned BURST = 256;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk_vga = 1'b0;
    logic        rst_n = 1'b0;
    logic        framestart = 1'b0;
    logic        prefetch_line = 1'b0;
    logic [3:0]  buf_sel_in = 4'd0;

    logic        busy[2];
    logic        kick[2];
    logic [31:0] read_addr[2];
    logic [15:0] read_num[2];
    logic [3:0]  active_buf[2];
    logic [11:0] line_cnt[2];
    logic        line_done[2];
    logic        overrun[2];

    int checks = 0;
    int errors = 0;

    always #5 clk_vga = ~clk_vga;

    hdmi_axi_addr_mb #(
        .X_SIZE(256), .Y_SIZE(256), .BYTES_PER_PIXEL(4), .BURST_BYTES(256), .NUM_BUF(2),
        .ADDR_W(32), .NUM_W(16), .BASE_ADDR(32'h1000_0000)
    ) dut0 (
        .clk_vga(clk_vga), .rst_n(rst_n), .framestart(framestart),
        .prefetch_line(prefetch_line), .buf_sel_in(buf_sel_in), .busy(busy[0]),
        .kick(kick[0]), .read_addr(read_addr[0]), .read_num(read_num[0]),
        .active_buf(active_buf[0]), .line_cnt(line_cnt[0]), .line_done(line_done[0]),
        .overrun(overrun[0])
    );

    hdmi_axi_addr_mb #(
        .X_SIZE(200), .Y_SIZE(256), .BYTES_PER_PIXEL(4), .BURST_BYTES(256), .NUM_BUF(2),
        .ADDR_W(32), .NUM_W(16), .BASE_ADDR(32'h1000_0000)
    ) dut1 (
        .clk_vga(clk_vga), .rst_n(rst_n), .framestart(framestart),
        .prefetch_line(prefetch_line), .buf_sel_in(buf_sel_in), .busy(busy[1]),
        .kick(kick[1]), .read_addr(read_addr[1]), .read_num(read_num[1]),
        .active_buf(active_buf[1]), .line_cnt(line_cnt[1]), .line_done(line_done[1]),
        .overrun(overrun[1])
    );

    function automatic int unsigned line_bytes(input int i);
        return (i == 0) ? 32'd1024 : 32'd800;
    endfunction

    // Read master stand-in: busy rises the cycle after kick, stays high 8..23 cycles.
    int hold_cnt[2];
    int burst_no[2] = '{0, 0};
    always @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                busy[i]     <= 1'b0;
                hold_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (kick[i]) begin
                    busy[i]     <= 1'b1;
                    hold_cnt[i] <= 8 + (burst_no[i] * 7) % 16;
                    burst_no[i] <= burst_no[i] + 1;
                end else if (busy[i]) begin
                    if (hold_cnt[i] <= 1) busy[i] <= 1'b0;
                    else hold_cnt[i] <= hold_cnt[i] - 1;
                end
            end
        end
    end

    // Reference model: a line is a list of byte chunks; the next chunk is requested one
    // cycle after acceptance or after the busy fall of the previous chunk.
    logic        m_in[2];   // line in flight
    logic        m_hi[2];   // busy seen high for the current chunk
    logic        m_kc[2];   // the current cycle carries a kick
    int unsigned m_rem[2];
    logic [31:0] m_addr[2];
    logic [11:0] m_cnt[2];
    logic [3:0]  m_ab[2];
    logic        m_ovr[2];
    logic        e_kick[2];
    logic        e_done[2];
    logic [31:0] e_addr[2];
    logic [15:0] e_num[2];

    always @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_in[i] <= 1'b0; m_hi[i] <= 1'b0; m_kc[i] <= 1'b0; m_rem[i] <= 0;
                m_addr[i] <= '0; m_cnt[i] <= '0; m_ab[i] <= '0; m_ovr[i] <= 1'b0;
                e_kick[i] <= 1'b0; e_done[i] <= 1'b0; e_addr[i] <= '0; e_num[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic        in_now, hi, ek, ed, ovr;
                int unsigned rem, num;
                logic [31:0] addr, ea;
                logic [11:0] cnt;
                logic [3:0]  ab;
                logic [15:0] en;
                in_now = m_in[i]; hi = m_hi[i]; rem = m_rem[i]; addr = m_addr[i];
                cnt = m_cnt[i]; ab = m_ab[i]; ovr = m_ovr[i];
                ek = 1'b0; ed = 1'b0; ea = e_addr[i]; en = e_num[i];
                if (in_now && !m_kc[i]) begin
                    if (!hi) begin
                        if (busy[i]) hi = 1'b1;
                    end else if (!busy[i]) begin
                        if (rem > 0) begin
                            num = (rem > BURST) ? BURST : rem;
                            ek = 1'b1; ea = addr; en = num[15:0];
                            addr = addr + BURST; rem = rem - num; hi = 1'b0;
                        end else begin
                            ed = 1'b1; in_now = 1'b0;
                        end
                    end
                end
                if (framestart) begin
                    cnt = '0; ovr = 1'b0;
                    if (buf_sel_in < NBUF) ab = buf_sel_in;
                end
                if (prefetch_line && cnt < Y) begin
                    if (!m_in[i]) begin
                        ea = BASE + 32'(ab) * (line_bytes(i) * Y) + 32'(cnt) * line_bytes(i);
                        num = (line_bytes(i) > BURST) ? BURST : line_bytes(i);
                        ek = 1'b1; en = num[15:0];
                        addr = ea + BURST; rem = line_bytes(i) - num;
                        in_now = 1'b1; hi = 1'b0;
                    end else begin
                        ovr = 1'b1;
                    end
                    cnt = cnt + 12'd1;
                end
                m_in[i] <= in_now; m_hi[i] <= hi; m_kc[i] <= ek; m_rem[i] <= rem;
                m_addr[i] <= addr; m_cnt[i] <= cnt; m_ab[i] <= ab; m_ovr[i] <= ovr;
                e_kick[i] <= ek; e_done[i] <= ed; e_addr[i] <= ea; e_num[i] <= en;
            end
        end
    end

    // Every-cycle comparison, plus a log of issued requests for the literal checks.
    logic [47:0] log0[$];
    logic [47:0] log1[$];
    int ld_cnt[2] = '{0, 0};

    always @(negedge clk_vga) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (kick[i] !== e_kick[i] || read_addr[i] !== e_addr[i] || read_num[i] !== e_num[i]
                || active_buf[i] !== m_ab[i] || line_cnt[i] !== m_cnt[i]
                || line_done[i] !== e_done[i] || overrun[i] !== m_ovr[i]) begin
                errors++;
                $display("FAIL cycle_cmp dut%0d t=%0t got kick=%b addr=%h num=%0d buf=%0d cnt=%0d done=%b ovr=%b want kick=%b addr=%h num=%0d buf=%0d cnt=%0d done=%b ovr=%b",
                         i, $time, kick[i], read_addr[i], read_num[i], active_buf[i],
                         line_cnt[i], line_done[i], overrun[i], e_kick[i], e_addr[i],
                         e_num[i], m_ab[i], m_cnt[i], e_done[i], m_ovr[i]);
            end
            if (line_done[i] === 1'b1) ld_cnt[i]++;
        end
        if (kick[0] === 1'b1) log0.push_back({read_addr[0], read_num[0]});
        if (kick[1] === 1'b1) log1.push_back({read_addr[1], read_num[1]});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input int inst, input int idx, input logic [31:0] ea,
                           input logic [15:0] en);
        logic [47:0] ent;
        int sz;
        sz = (inst == 0) ? log0.size() : log1.size();
        if (idx >= sz) begin
            checks++;
            errors++;
            $display("FAIL kick_log dut%0d entry %0d missing (have %0d)", inst, idx, sz);
        end else begin
            ent = (inst == 0) ? log0[idx] : log1[idx];
            chk($sformatf("kick_addr dut%0d #%0d", inst, idx), ent[47:16], ea);
            chk($sformatf("kick_num dut%0d #%0d", inst, idx), 32'(ent[15:0]), 32'(en));
        end
    endtask

    task automatic pulse(input logic fs, input logic pf, input logic [3:0] bs);
        @(negedge clk_vga);
        framestart = fs; prefetch_line = pf; buf_sel_in = bs;
        @(negedge clk_vga);
        framestart = 1'b0; prefetch_line = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_in[0] || m_in[1]) && n < 3000) begin
            @(negedge clk_vga);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got %0d cycles want < 3000", n);
        end
        repeat (3) @(negedge clk_vga);
    endtask

    initial begin
        int b0, b1;
        repeat (3) @(negedge clk_vga);
        chk("rst_kick", 32'(kick[0]), 32'd0);
        chk("rst_addr", read_addr[0], 32'd0);
        chk("rst_num", 32'(read_num[1]), 32'd0);
        chk("rst_cnt", 32'(line_cnt[0]), 32'd0);
        rst_n = 1'b1;

        // Full-burst line and partial-last-burst line, then the next line.
        pulse(1'b1, 1'b0, 4'd0);
        pulse(1'b0, 1'b1, 4'd0);
        wait_idle();
        chk_log(0, 0, 32'h1000_0000, 16'd256);
        chk_log(0, 1, 32'h1000_0100, 16'd256);
        chk_log(0, 2, 32'h1000_0200, 16'd256);
        chk_log(0, 3, 32'h1000_0300, 16'd256);
        chk("s1_kicks", 32'(log0.size()), 32'd4);
        chk("s1_line_done", 32'(ld_cnt[0]), 32'd1);
        chk_log(1, 0, 32'h1000_0000, 16'd256);
        chk_log(1, 1, 32'h1000_0100, 16'd256);
        chk_log(1, 2, 32'h1000_0200, 16'd256);
        chk_log(1, 3, 32'h1000_0300, 16'd32);
        chk("s2_kicks", 32'(log1.size()), 32'd4);
        pulse(1'b0, 1'b1, 4'd0);
        wait_idle();
        chk_log(0, 4, 32'h1000_0400, 16'd256);
        chk_log(1, 4, 32'h1000_0320, 16'd256);
        chk("s1_line_cnt", 32'(line_cnt[0]), 32'd2);

        // Buffer selection, including an out-of-range request.
        pulse(1'b1, 1'b0, 4'd1);
        chk("s3_buf", 32'(active_buf[0]), 32'd1);
        pulse(1'b0, 1'b1, 4'd0);
        wait_idle();
        chk_log(0, 8, 32'h1004_0000, 16'd256);
        chk_log(1, 8, 32'h1003_2000, 16'd256);
        pulse(1'b1, 1'b0, 4'd5);
        chk("s3_buf_keep", 32'(active_buf[0]), 32'd1);

        // Dropped prefetch while a line is in flight.
        pulse(1'b0, 1'b1, 4'd0);
        repeat (5) @(negedge clk_vga);
        pulse(1'b0, 1'b1, 4'd0);
        chk("s4_overrun", 32'(overrun[0]), 32'd1);
        wait_idle();
        chk("s4_line_cnt", 32'(line_cnt[0]), 32'd2);
        pulse(1'b0, 1'b1, 4'd0);
        wait_idle();
        chk("s4_kicks", 32'(log0.size()), 32'd20);
        chk_log(0, 16, 32'h1004_0800, 16'd256);
        chk_log(1, 16, 32'h1003_2640, 16'd256);
        pulse(1'b1, 1'b0, 4'd0);
        chk("s4_overrun_clr", 32'(overrun[0]), 32'd0);

        // 257 pulses in a 256-line frame, then framestart+prefetch together.
        b0 = log0.size();
        b1 = log1.size();
        for (int k = 0; k < 257; k++) begin
            pulse(1'b0, 1'b1, 4'd0);
            wait_idle();
        end
        chk("s5_kicks0", 32'(log0.size() - b0), 32'd1024);
        chk("s5_kicks1", 32'(log1.size() - b1), 32'd1024);
        chk("s5_line_cnt", 32'(line_cnt[0]), 32'd256);
        b0 = log0.size();
        pulse(1'b1, 1'b1, 4'd0);
        chk("s5_fs_pf_cnt", 32'(line_cnt[0]), 32'd1);
        wait_idle();
        chk_log(0, b0, 32'h1000_0000, 16'd256);

        // Reset while waiting for busy to rise.
        pulse(1'b0, 1'b1, 4'd0);
        @(posedge clk_vga);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_kick", 32'(kick[0]), 32'd0);
        chk("s6_addr", read_addr[0], 32'd0);
        chk("s6_num", 32'(read_num[0]), 32'd0);
        chk("s6_cnt", 32'(line_cnt[0]), 32'd0);
        repeat (2) @(negedge clk_vga);
        rst_n = 1'b1;
        b0 = log0.size();
        pulse(1'b1, 1'b0, 4'd0);
        pulse(1'b0, 1'b1, 4'd0);
        wait_idle();
        chk("s6_kicks", 32'(log0.size() - b0), 32'd4);
        chk_log(0, b0, 32'h1000_0000, 16'd256);
        chk_log(0, b0 + 3, 32'h1000_0300, 16'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_axi_addr_mb.md
Name: hdmi_axi_addr_mb

Overview:
Parametrised successor to the HDMI line-prefetch address generator. Converts each prefetch_line pulse into a sequence of DRAM read requests (kick/busy handshake) covering one display line, split into bursts of at most BURST_BYTES. Adds multi-buffer frame selection latched at frame start, configurable pixel size, line stride and burst size, partial last burst, a frame-end guard and overrun detection. Sits between syncgen and the AXI read master in the DRAM-to-HDMI path.

Parameters:
X_SIZE, 1280, active pixels per line
Y_SIZE, 720, active lines per frame
BYTES_PER_PIXEL, 4, bytes per pixel in DRAM
BURST_BYTES, 256, maximum bytes per request; must be a power of two and ≤ 2^NUM_W-1
NUM_BUF, 2, number of frame buffers (1..16)
BASE_ADDR, 32'h1000_0000, byte address of buffer 0, line 0
LINE_STRIDE, X_SIZE*BYTES_PER_PIXEL, byte distance between lines
FRAME_STRIDE, LINE_STRIDE*Y_SIZE, byte distance between buffers
ADDR_W, 32, address width
NUM_W, 16, read_num width

Ports:
clk_vga  in  1  video clock; all logic in this domain
rst_n  in  1  asynchronous active-low reset
framestart  in  1  one-cycle pulse at frame start (from syncgen)
prefetch_line  in  1  one-cycle pulse requesting the next line fetch
buf_sel_in  in  4  requested buffer index, sampled on framestart
busy  in  1  read master busy; rises after kick, falls when the request completes
kick  out  1  one-cycle request strobe
read_addr  out  ADDR_W  byte address of the request; valid on kick, held until the next kick
read_num  out  NUM_W  byte count of the request; valid on kick, held until the next kick
active_buf  out  4  buffer currently being read
line_cnt  out  12  next line index to be fetched (0..Y_SIZE)
line_done  out  1  one-cycle pulse after the last burst of a line completes
overrun  out  1  sticky; set when prefetch_line is dropped; cleared on framestart

Behaviour:
- Reset (async, rst_n=0): kick=0, read_addr=0, read_num=0, active_buf=0, line_cnt=0, line_done=0, overrun=0, FSM=IDLE. Reset mid-request abandons the request; on reset release the block waits for a new pulse.
- FSM states:
  - IDLE → ISSUE on an accepted prefetch_line.
  - ISSUE: kick=1 for exactly one cycle with read_addr/read_num, then WAIT_HI.
  - WAIT_HI: waits for busy=1, then WAIT_LO.
  - WAIT_LO: waits for busy=0; if bytes remain → ISSUE, else line_done=1 for one cycle → IDLE.
- kick is never asserted twice without an intervening busy high→low cycle.
- framestart:
  - line_cnt←0, overrun←0.
  - active_buf←buf_sel_in if buf_sel_in<NUM_BUF, else active_buf is unchanged.
  - An in-flight line fetch completes normally with its latched address.
- Accepting prefetch_line (FSM=IDLE and line_cnt<Y_SIZE):
  - Latch line_addr = BASE_ADDR + active_buf*FRAME_STRIDE + line_cnt*LINE_STRIDE.
  - Set remaining = X_SIZE*BYTES_PER_PIXEL, then line_cnt++.
  - The first kick occurs on the cycle after acceptance, so latency from pulse to kick is 1 cycle.
- Bursts: read_num = min(BURST_BYTES, remaining). read_addr starts at line_addr and advances by BURST_BYTES each burst. The last burst may be partial.
- prefetch_line while FSM≠IDLE: request dropped, line_cnt++ (display alignment is kept), overrun←1.
- prefetch_line when line_cnt==Y_SIZE: ignored. No kick, no counter change, no overrun.
- framestart and prefetch_line in the same cycle: framestart applies first. The pulse fetches line 0 of the newly selected buffer, if FSM=IDLE.
- All address arithmetic is unsigned modulo 2^ADDR_W. Multiplies are by constants or narrow counters.

Test Plan:
1. X_SIZE=256, BPP=4, BURST=256, BASE=0x1000_0000, buf 0, framestart then prefetch_line, with busy responding 1 cycle after kick and held 8–23 cycles → 4 kicks at 0x1000_0000/0100/0200/0300, read_num=256 each, line_done once; second line starts at 0x1000_0400.
2. X_SIZE=200 → kicks with read_num 256, 256, 256, 32 at offsets 0x000, 0x100, 0x200, 0x300.
3. framestart with buf_sel_in=1 (Y_SIZE=256, FRAME_STRIDE=0x40000) → first kick at 0x1004_0000, active_buf=1. buf_sel_in=5 with NUM_BUF=2 → active_buf unchanged.
4. prefetch_line while in WAIT_LO → no extra kick, overrun=1, line_cnt advances by 2 in total. Next accepted line address skips the dropped line. overrun clears on the next framestart.
5. 257 prefetch_line pulses with Y_SIZE=256 → exactly 256 line fetches; the 257th produces no kick. Simultaneous framestart+prefetch_line → line 0 is fetched.
6. rst_n low during WAIT_HI → kick=0, all outputs 0 immediately. After release, the next framestart+prefetch_line sequence behaves as in scenario 1.
